rob_ptr_ctrl: RTL and testbench

Reorder-buffer pointer and retirement controller for the out-of-order backend. It allocates ROB entries to the scheduler in issue-width groups and tracks per-entry completion and exception status from writeback. It retires up to COMMIT_WIDTH completed entries per cycle in program order and raises a one-cycle flush when the oldest entry carries an exception. The commit stage uses its commit mask and indices to release architectural register writes.

---
 rtl/rob_ptr_ctrl.sv | 153 +++++++++++++++
 tb/tb_rob_ptr_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ptr_ctrl.sv
// Reorder-buffer pointer/retire controller: allocates issue groups, tracks completion,
// retires in order up to COMMIT_WIDTH per cycle and pulses a flush on a head exception.
module rob_ptr_ctrl #(
   parameter int ROB_DEPTH    = 16,
   parameter int ISSUE_WIDTH  = 2,
   parameter int COMMIT_WIDTH = 2,
   parameter int WB_PORTS     = 2,
   parameter int IDX_W        = $clog2(ROB_DEPTH)
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_flush,
   input  logic                          i_enqueue,
   output logic                          o_rob_avail,
   output logic [ISSUE_WIDTH*IDX_W-1:0]  o_rob_idx,
   input  logic [WB_PORTS-1:0]           i_wb_valid,
   input  logic [WB_PORTS*IDX_W-1:0]     i_wb_idx,
   input  logic [WB_PORTS-1:0]           i_wb_exc,
   output logic [COMMIT_WIDTH-1:0]       o_commit_valid,
   output logic [COMMIT_WIDTH*IDX_W-1:0] o_commit_idx,
   output logic                          o_flush,
   output logic [IDX_W-1:0]              o_except_idx
);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   localparam logic [IDX_W:0] DEPTH_P = (IDX_W+1)'(ROB_DEPTH);
   localparam logic [IDX_W:0] ISSUE_P = (IDX_W+1)'(ISSUE_WIDTH);

   state_t                  state;
   logic [IDX_W:0]          head;
   logic [IDX_W:0]          tail;
   logic [ROB_DEPTH-1:0]    ent_valid;
   logic [ROB_DEPTH-1:0]    ent_done;
   logic [ROB_DEPTH-1:0]    ent_exc;

   logic [IDX_W:0]          count;
   logic [IDX_W:0]          free_slots;
   logic                    enq_acc;
   logic                    take_exc;
   logic [COMMIT_WIDTH-1:0] commit_valid;
   logic [IDX_W:0]          commit_cnt;
   logic                    chain;
   logic [IDX_W-1:0]        c_slot;
   logic [IDX_W-1:0]        w_slot;
   logic [IDX_W-1:0]        r_slot;
   logic [IDX_W-1:0]        a_slot;
   logic [ROB_DEPTH-1:0]    wb_hit;
   logic [ROB_DEPTH-1:0]    wb_exc;
   logic [ROB_DEPTH-1:0]    valid_nxt;
   logic [ROB_DEPTH-1:0]    done_nxt;
   logic [ROB_DEPTH-1:0]    exc_nxt;

   assign count       = tail - head;
   assign free_slots  = DEPTH_P - count;
   assign o_rob_avail = (state == RUN) && !i_flush && (free_slots >= ISSUE_P);
   assign enq_acc     = i_enqueue && o_rob_avail;
   assign take_exc    = (state == RUN) && !i_flush && ent_valid[head[IDX_W-1:0]] &&
                        ent_done[head[IDX_W-1:0]] && ent_exc[head[IDX_W-1:0]];

   for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_alloc_idx
      assign o_rob_idx[k*IDX_W +: IDX_W] = tail[IDX_W-1:0] + IDX_W'(k);
   end

   for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_commit_idx
      assign o_commit_idx[k*IDX_W +: IDX_W] = head[IDX_W-1:0] + IDX_W'(k);
   end

   // Retire run stops at the first entry that is not cleanly complete or beyond tail.
   always_comb begin
      commit_valid = '0;
      commit_cnt   = '0;
      c_slot       = '0;
      chain        = (state == RUN) && !i_flush;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         c_slot = head[IDX_W-1:0] + IDX_W'(k);
         chain  = chain && ent_valid[c_slot] && ent_done[c_slot] && !ent_exc[c_slot] &&
                  ((IDX_W+1)'(k) < count);
         commit_valid[k] = chain;
         if (chain) commit_cnt = commit_cnt + (IDX_W+1)'(1);
      end
   end

   assign o_commit_valid = commit_valid;

   // Writeback first, then retire clears, then allocation of free slots.
   always_comb begin
      wb_hit = '0;
      wb_exc = '0;
      w_slot = '0;
      r_slot = '0;
      a_slot = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         w_slot = i_wb_idx[p*IDX_W +: IDX_W];
         if (i_wb_valid[p] && ent_valid[w_slot]) begin
            wb_hit[w_slot] = 1'b1;
            wb_exc[w_slot] = wb_exc[w_slot] | i_wb_exc[p];
         end
      end
      valid_nxt = ent_valid;
      done_nxt  = ent_done | wb_hit;
      exc_nxt   = (ent_exc & ~wb_hit) | wb_exc;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         r_slot = head[IDX_W-1:0] + IDX_W'(k);
         if (commit_valid[k]) begin
            valid_nxt[r_slot] = 1'b0;
            done_nxt[r_slot]  = 1'b0;
            exc_nxt[r_slot]   = 1'b0;
         end
      end
      if (enq_acc) begin
         for (int k = 0; k < ISSUE_WIDTH; k++) begin
            a_slot = tail[IDX_W-1:0] + IDX_W'(k);
            valid_nxt[a_slot] = 1'b1;
            done_nxt[a_slot]  = 1'b0;
            exc_nxt[a_slot]   = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= RUN;
         head         <= '0;
         tail         <= '0;
         ent_valid    <= '0;
         ent_done     <= '0;
         ent_exc      <= '0;
         o_flush      <= 1'b0;
         o_except_idx <= '0;
      end else if (i_flush || state == FLUSH) begin
         state     <= RUN;
         head      <= '0;
         tail      <= '0;
         ent_valid <= '0;
         ent_done  <= '0;
         ent_exc   <= '0;
         o_flush   <= 1'b0;
      end else begin
         if (take_exc) begin
            state        <= FLUSH;
            o_flush      <= 1'b1;
            o_except_idx <= head[IDX_W-1:0];
         end
         head      <= head + commit_cnt;
         tail      <= enq_acc ? tail + ISSUE_P : tail;
         ent_valid <= valid_nxt;
         ent_done  <= done_nxt;
         ent_exc   <= exc_nxt;
      end
   end

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Directed bench for rob_ptr_ctrl: allocation, out-of-order completion, exception flush,
// wrap-around, external flush priority and asynchronous reset during FLUSH.
module tb_rob_ptr_ctrl;

   localparam int IDX_W = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       enq;
   logic       avail;
   logic [7:0] rob_idx;
   logic [1:0] wb_valid;
   logic [7:0] wb_idx;
   logic [1:0] wb_exc;
   logic [1:0] commit_valid;
   logic [7:0] commit_idx;
   logic       flush_out;
   logic [3:0] except_idx;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rob_ptr_ctrl #(
      .ROB_DEPTH(16), .ISSUE_WIDTH(2), .COMMIT_WIDTH(2), .WB_PORTS(2), .IDX_W(IDX_W)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_flush        (flush),
      .i_enqueue      (enq),
      .o_rob_avail    (avail),
      .o_rob_idx      (rob_idx),
      .i_wb_valid     (wb_valid),
      .i_wb_idx       (wb_idx),
      .i_wb_exc       (wb_exc),
      .o_commit_valid (commit_valid),
      .o_commit_idx   (commit_idx),
      .o_flush        (flush_out),
      .o_except_idx   (except_idx)
   );

   function automatic logic [7:0] pk(input int lane0, input int lane1);
      logic [3:0] a;
      logic [3:0] b;
      a = 4'(lane0);
      b = 4'(lane1);
      return {b, a};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; enq = 1'b0;
      wb_valid = '0; wb_idx = '0; wb_exc = '0;
      #12 rst_n = 1'b1;
      #1;
      check("rst_avail", 32'(avail), 32'd1);
      check("rst_cv", 32'(commit_valid), 32'd0);
      check("rst_rob_idx", 32'(rob_idx), 32'(pk(0, 1)));
      check("rst_flush", 32'(flush_out), 32'd0);
      check("rst_exc_idx", 32'(except_idx), 32'd0);

      // fill the ROB with eight issue groups
      for (int i = 0; i < 8; i++) begin
         enq = 1'b1;
         #1;
         check("fill_idx", 32'(rob_idx), 32'(pk(2*i, 2*i+1)));
         check("fill_avail", 32'(avail), 32'd1);
         cyc();
      end
      #1;
      check("full_avail", 32'(avail), 32'd0);
      check("full_idx", 32'(rob_idx), 32'(pk(0, 1)));
      check("full_cv", 32'(commit_valid), 32'd0);
      cyc();
      check("full_tail_held", 32'(rob_idx), 32'(pk(0, 1)));
      check("full_head", 32'(commit_idx), 32'(pk(0, 1)));
      enq = 1'b0;
      flush = 1'b1;
      #1;
      cyc();
      flush = 1'b0;
      #1;
      check("post_flush_avail", 32'(avail), 32'd1);

      // out-of-order completion
      enq = 1'b1; #1; cyc();
      enq = 1'b1; #1; cyc();
      enq = 1'b0;
      wb_valid = 2'b11; wb_idx = pk(2, 3);
      #1;
      check("ooo_cv0", 32'(commit_valid), 32'd0);
      cyc();
      wb_valid = 2'b01; wb_idx = pk(0, 0);
      #1;
      check("ooo_cv1", 32'(commit_valid), 32'd0);
      cyc();
      wb_valid = 2'b01; wb_idx = pk(1, 0);
      #1;
      check("ooo_cv2", 32'(commit_valid), 32'b01);
      check("ooo_ci2", 32'(commit_idx), 32'(pk(0, 1)));
      cyc();
      wb_valid = 2'b00;
      #1;
      check("ooo_cv3", 32'(commit_valid), 32'b11);
      check("ooo_ci3", 32'(commit_idx), 32'(pk(1, 2)));
      cyc();
      #1;
      check("ooo_cv4", 32'(commit_valid), 32'b01);
      check("ooo_ci4", 32'(commit_idx), 32'(pk(3, 4)));
      cyc();
      #1;
      check("ooo_cv5", 32'(commit_valid), 32'd0);
      check("ooo_avail", 32'(avail), 32'd1);
      check("ooo_tail", 32'(rob_idx), 32'(pk(4, 5)));

      // exception on entry 1
      flush = 1'b1; #1; cyc();
      flush = 1'b0;
      enq = 1'b1; #1; cyc();
      enq = 1'b1; #1; cyc();
      enq = 1'b0;
      wb_valid = 2'b11; wb_idx = pk(0, 1); wb_exc = 2'b10;
      #1;
      cyc();
      wb_idx = pk(2, 3); wb_exc = 2'b00;
      #1;
      check("exc_cv0", 32'(commit_valid), 32'b01);
      check("exc_ci0", 32'(commit_idx), 32'(pk(0, 1)));
      check("exc_flush0", 32'(flush_out), 32'd0);
      cyc();
      wb_valid = 2'b00;
      #1;
      check("exc_cv1", 32'(commit_valid), 32'd0);
      check("exc_flush1", 32'(flush_out), 32'd0);
      cyc();
      enq = 1'b1;
      #1;
      check("exc_flush2", 32'(flush_out), 32'd1);
      check("exc_idx2", 32'(except_idx), 32'd1);
      check("exc_avail2", 32'(avail), 32'd0);
      check("exc_cv2", 32'(commit_valid), 32'd0);
      cyc();
      enq = 1'b0;
      #1;
      check("exc_flush3", 32'(flush_out), 32'd0);
      check("exc_avail3", 32'(avail), 32'd1);
      check("exc_rob_idx3", 32'(rob_idx), 32'(pk(0, 1)));
      check("exc_head3", 32'(commit_idx), 32'(pk(0, 1)));

      // advance head and tail to 14, then straddle the wrap
      for (int i = 0; i < 7; i++) begin
         enq = 1'b1; #1; cyc();
         enq = 1'b0;
         wb_valid = 2'b11; wb_idx = pk(2*i, 2*i+1);
         #1;
         cyc();
         wb_valid = 2'b00;
         #1;
         check("adv_cv", 32'(commit_valid), 32'b11);
         cyc();
      end
      #1;
      check("wrap_tail14", 32'(rob_idx), 32'(pk(14, 15)));
      check("wrap_head14", 32'(commit_idx), 32'(pk(14, 15)));
      check("wrap_avail14", 32'(avail), 32'd1);
      enq = 1'b1;
      cyc();
      check("wrap_tail0", 32'(rob_idx), 32'(pk(0, 1)));
      cyc();
      enq = 1'b0;
      wb_valid = 2'b11; wb_idx = pk(14, 15);
      #1;
      cyc();
      wb_idx = pk(0, 1);
      #1;
      check("wrap_cv0", 32'(commit_valid), 32'b11);
      check("wrap_ci0", 32'(commit_idx), 32'(pk(14, 15)));
      cyc();
      wb_valid = 2'b00;
      #1;
      check("wrap_cv1", 32'(commit_valid), 32'b11);
      check("wrap_ci1", 32'(commit_idx), 32'(pk(0, 1)));
      cyc();
      #1;
      check("wrap_cv2", 32'(commit_valid), 32'd0);
      check("wrap_avail2", 32'(avail), 32'd1);
      check("wrap_tail2", 32'(rob_idx), 32'(pk(2, 3)));
      check("wrap_head2", 32'(commit_idx), 32'(pk(2, 3)));

      // external flush beats enqueue, writeback and a pending commit
      enq = 1'b1; #1; cyc();
      enq = 1'b0;
      wb_valid = 2'b11; wb_idx = pk(2, 3);
      #1;
      cyc();
      flush = 1'b1; enq = 1'b1; wb_valid = 2'b11; wb_idx = pk(2, 3);
      #1;
      check("xf_cv", 32'(commit_valid), 32'd0);
      check("xf_avail", 32'(avail), 32'd0);
      cyc();
      flush = 1'b0; enq = 1'b0; wb_valid = 2'b00;
      #1;
      check("xf_flush_out", 32'(flush_out), 32'd0);
      check("xf_avail_after", 32'(avail), 32'd1);
      check("xf_tail", 32'(rob_idx), 32'(pk(0, 1)));
      check("xf_head", 32'(commit_idx), 32'(pk(0, 1)));
      check("xf_cv_after", 32'(commit_valid), 32'd0);

      // both ports hit entry 0, one with exception; then reset during FLUSH
      enq = 1'b1; #1; cyc();
      enq = 1'b0;
      wb_valid = 2'b11; wb_idx = pk(0, 0); wb_exc = 2'b10;
      #1;
      cyc();
      wb_valid = 2'b00; wb_exc = 2'b00;
      #1;
      check("dup_cv", 32'(commit_valid), 32'd0);
      check("dup_flush0", 32'(flush_out), 32'd0);
      cyc();
      #1;
      check("dup_flush1", 32'(flush_out), 32'd1);
      check("dup_exc_idx", 32'(except_idx), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_flush", 32'(flush_out), 32'd0);
      check("arst_avail", 32'(avail), 32'd1);
      check("arst_cv", 32'(commit_valid), 32'd0);
      #3 rst_n = 1'b1;
      cyc();
      #1;
      check("arst_avail2", 32'(avail), 32'd1);
      check("arst_tail", 32'(rob_idx), 32'(pk(0, 1)));
      check("arst_head", 32'(commit_idx), 32'(pk(0, 1)));
      check("arst_cv2", 32'(commit_valid), 32'd0);
      check("arst_flush2", 32'(flush_out), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
